rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
//  N-client arbiter/sequencer for the shared RTC protocol engine bus. Clients are the init, read-loop and
//  user-write/set machines. One client owns the bus per transaction. Its addr/wdata/mode are presented to
//  the protocol engine until the engine signals completion. Bus ownership changes only at transaction
//  boundaries, so a request never cuts an engine cycle short. Per-transaction timeout and error reporting.
// PARAMETERS
//  N_CLIENTS      3    number of requesting machines (>=2); index 0 is highest fixed priority
//  AW             8    RTC address width
//  DW             8    RTC data width
//  ROUND_ROBIN    0    0 = fixed priority (lowest index wins), 1 = rotating priority after each grant
//  GUARD_CYCLES   2    idle cycles forced between transactions (0 allowed)
//  TIMEOUT_CYCLES 255  max cycles in WAIT before abort (>=1); counter width = clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk        in   1            system clock
//  reset      in   1            sync, active-high
//  req        in   N_CLIENTS    per-client transaction request (level)
//  req_write  in   N_CLIENTS    per-client mode: 1 = write, 0 = read
//  req_addr   in   N_CLIENTS*AW packed addresses, client i at [i*AW +: AW]
//  req_wdata  in   N_CLIENTS*DW packed write data, client i at [i*DW +: DW]
//  gnt        out  N_CLIENTS    one-hot grant, held through the transaction
//  rd_valid   out  N_CLIENTS    one-cycle pulse to owner when read data is valid
//  rd_data    out  DW           read data, valid with rd_valid, held until the next read completes
//  err        out  N_CLIENTS    one-cycle pulse to owner on timeout abort
//  txn_start  out  1            one-cycle start pulse to protocol engine
//  txn_write  out  1            mode to engine, stable from txn_start to done
//  txn_addr   out  AW           address to engine, stable from txn_start to done
//  txn_wdata  out  DW           write data to engine; 0 during reads
//  txn_done   in   1            one-cycle completion pulse from engine
//  txn_rdata  in   DW           engine read data, valid with txn_done
//  busy       out  1            high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. gnt, rd_valid, err, txn_start, txn_write, busy = 0. txn_addr, txn_wdata,
//   rd_data = 0. RR pointer = 0. Reset mid-transaction drops ownership on the next edge.
//   The engine is not notified of the abort.
//  States: IDLE -> GRANT -> WAIT -> GUARD -> IDLE. All outputs are registered.
//  IDLE: if any req at edge t: pick winner w. At t+1: gnt[w]=1, txn_start=1 (one cycle),
//   txn_addr/txn_write/txn_wdata latched from client w. State goes to WAIT (GRANT is the start-pulse cycle).
//  Arbitration: ROUND_ROBIN=0 -> lowest set index. ROUND_ROBIN=1 -> first set index at or after ptr,
//   wrapping modulo N_CLIENTS. ptr <= w+1 (wraps to 0 after N_CLIENTS-1) on each grant.
//  Payload is latched at grant. Later changes to the client's inputs are ignored until the next grant.
//  WAIT: timeout counter starts at 0 and increments each cycle. txn_done is accepted in WAIT, and
//   also in the GRANT cycle.
//   On txn_done at edge t: gnt cleared at t+1. If txn_write=0: rd_data<=txn_rdata and rd_valid[w]=1 at t+1.
//   Write completion gives no rd_valid.
//   If the counter reaches TIMEOUT_CYCLES without done: err[w] pulse, gnt cleared, go to GUARD.
//   txn_done and timeout on the same edge: done wins, no err.
//  GUARD: counts GUARD_CYCLES cycles with busy=1, then IDLE. GUARD_CYCLES=0 goes straight to IDLE.
//   Minimum request-to-request spacing for one client = 3+GUARD_CYCLES cycles.
//  A client dropping req while it owns the bus does not abort. Ownership ends only on done, timeout or reset.
//  txn_done outside GRANT/WAIT is ignored: no rd_valid, no state change.
//  Requests arriving while busy=1 wait. They are arbitrated in IDLE only. No request is lost while held.
// TESTING
//  N=3, AW=DW=8, GUARD=2, TIMEOUT=20 unless stated.
//  1. Reset: hold reset 3 cycles with req=3'b111 -> gnt=0, txn_start=0, busy=0.
//     Release -> gnt=3'b001 on the next cycle.
//  2. Fixed prio: req=3'b110, client1 read addr 8'h21.
//     -> gnt=3'b010, txn_addr=8'h21, txn_write=0.
//     Engine done with rdata 8'h45 -> rd_valid=3'b010, rd_data=8'h45.
//     After 2 guard cycles -> gnt=3'b100.
//  3. Write: client2 write addr 8'h22 wdata 8'h59 -> txn_write=1, txn_wdata=8'h59.
//     Done -> no rd_valid, gnt=0 next cycle.
//  4. Timeout: grant client0, never pulse done -> err=3'b001 after 20 WAIT cycles, gnt=0, then IDLE.
//     Done and timeout on the same edge -> no err.
//  5. ROUND_ROBIN=1, req=3'b111 held for 6 transactions -> grant order 0,1,2,0,1,2.
//  6. Reset asserted during WAIT -> next cycle IDLE, gnt=0. A late txn_done is ignored (rd_valid stays 0).

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// Bus bundle between the RTC requesting machines, the arbiter and the protocol engine.
// The master modport is the arbiter's view; the slave modport is the clients' and engine's view.
interface rtc_bus_arbiter_if #(
  parameter int N_CLIENTS = 3,
  parameter int AW        = 8,
  parameter int DW        = 8
);
  logic [N_CLIENTS-1:0]    req;
  logic [N_CLIENTS-1:0]    req_write;
  logic [N_CLIENTS*AW-1:0] req_addr;
  logic [N_CLIENTS*DW-1:0] req_wdata;
  logic [N_CLIENTS-1:0]    gnt;
  logic [N_CLIENTS-1:0]    rd_valid;
  logic [DW-1:0]           rd_data;
  logic [N_CLIENTS-1:0]    err;
  logic                    txn_start;
  logic                    txn_write;
  logic [AW-1:0]           txn_addr;
  logic [DW-1:0]           txn_wdata;
  logic                    txn_done;
  logic [DW-1:0]           txn_rdata;
  logic                    busy;

  modport master (
    input  req, req_write, req_addr, req_wdata, txn_done, txn_rdata,
    output gnt, rd_valid, rd_data, err, txn_start, txn_write, txn_addr, txn_wdata, busy
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, txn_done, txn_rdata,
    input  gnt, rd_valid, rd_data, err, txn_start, txn_write, txn_addr, txn_wdata, busy
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Arbiter/sequencer for the shared RTC protocol engine: one client owns the engine per
// transaction, with fixed or rotating priority, a per-transaction timeout and forced guard gaps.
module rtc_bus_arbiter #(
  parameter int N_CLIENTS      = 3,
  parameter int AW             = 8,
  parameter int DW             = 8,
  parameter int ROUND_ROBIN    = 0,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  rtc_bus_arbiter_if.master   bus
);

  localparam int PW   = $clog2(N_CLIENTS);
  localparam int CMAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_GUARD
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [N_CLIENTS-1:0]  gnt_q, gnt_d;
  logic [N_CLIENTS-1:0]  rd_valid_q, rd_valid_d;
  logic [N_CLIENTS-1:0]  err_q, err_d;
  logic [DW-1:0]         rd_data_q, rd_data_d;
  logic                  txn_start_q, txn_start_d;
  logic                  txn_write_q, txn_write_d;
  logic [AW-1:0]         txn_addr_q, txn_addr_d;
  logic [DW-1:0]         txn_wdata_q, txn_wdata_d;
  logic                  busy_q, busy_d;

  // Per-client payload unpacked once so the winner can be indexed directly.
  logic [AW-1:0]         addr_arr  [N_CLIENTS];
  logic [DW-1:0]         wdata_arr [N_CLIENTS];

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      addr_arr[i]  = bus.req_addr[i*AW +: AW];
      wdata_arr[i] = bus.req_wdata[i*DW +: DW];
    end
  end

  // Winner search starts at the rotating pointer in round-robin mode, at client 0 otherwise.
  logic [PW-1:0] start_idx;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;
  int            pos;

  always_comb begin
    start_idx = (ROUND_ROBIN != 0) ? ptr_q : '0;
    win       = '0;
    found     = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      pos = int'(start_idx) + k;
      if (pos >= N_CLIENTS) pos = pos - N_CLIENTS;
      idx = PW'(pos);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    rd_valid_d  = '0;
    err_d       = '0;
    rd_data_d   = rd_data_q;
    txn_start_d = 1'b0;
    txn_write_d = txn_write_q;
    txn_addr_d  = txn_addr_q;
    txn_wdata_d = txn_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_GRANT;
          owner_d     = win;
          gnt_d       = {{(N_CLIENTS-1){1'b0}}, 1'b1} << win;
          txn_start_d = 1'b1;
          txn_write_d = bus.req_write[win];
          txn_addr_d  = addr_arr[win];
          txn_wdata_d = bus.req_write[win] ? wdata_arr[win] : '0;
          ptr_d       = (win == PW'(N_CLIENTS - 1)) ? '0 : win + 1'b1;
          cnt_d       = '0;
        end
      end

      S_GRANT, S_WAIT: begin
        if (bus.txn_done) begin
          // Completion has priority over a timeout landing on the same edge.
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
          if (!txn_write_q) begin
            rd_data_d           = bus.txn_rdata;
            rd_valid_d[owner_q] = 1'b1;
          end
        end else if (state_q == S_GRANT) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          gnt_d          = '0;
          cnt_d          = '0;
          err_d[owner_q] = 1'b1;
          state_d        = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GUARD: begin
        if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      err_q       <= '0;
      rd_data_q   <= '0;
      txn_start_q <= 1'b0;
      txn_write_q <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      txn_start_q <= txn_start_d;
      txn_write_q <= txn_write_d;
      txn_addr_q  <= txn_addr_d;
      txn_wdata_q <= txn_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.err       = err_q;
  assign bus.txn_start = txn_start_q;
  assign bus.txn_write = txn_write_q;
  assign bus.txn_addr  = txn_addr_q;
  assign bus.txn_wdata = txn_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: a cycle table for the fixed-priority flow, then
// hand sequences for timeout, done/timeout collision, reset mid-transaction and round-robin.
module tb_rtc_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rtc_bus_arbiter_if #(.N_CLIENTS(N), .AW(AW), .DW(DW)) bus_fp ();
  rtc_bus_arbiter_if #(.N_CLIENTS(N), .AW(AW), .DW(DW)) bus_rr ();

  rtc_bus_arbiter #(
    .N_CLIENTS(N), .AW(AW), .DW(DW), .ROUND_ROBIN(0), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(20)
  ) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp)
  );

  rtc_bus_arbiter #(
    .N_CLIENTS(N), .AW(AW), .DW(DW), .ROUND_ROBIN(1), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(20)
  ) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [23:0] addr;
    logic        done;
    logic [7:0]  rdata;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rdv;
    logic        e_start;
    logic        e_busy;
    logic        chk_txn;
    logic        e_write;
    logic [7:0]  e_addr;
    logic [7:0]  e_wdata;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs[$];

  // Clients: 0 reads 0x20, 1 reads 0x21 (its wdata 0x77 must not reach the engine), 2 writes 0x59 to 0x22.
  localparam logic [23:0] ADDR_A = 24'h222120;
  localparam logic [23:0] ADDR_B = 24'h229920;
  localparam logic [23:0] WDATA  = 24'h597733;
  localparam logic [2:0]  WMODE  = 3'b100;

  function automatic vec_t mk(
    input logic rst, input logic [2:0] req, input logic [23:0] addr, input logic done,
    input logic [7:0] rdata, input logic [2:0] e_gnt, input logic [2:0] e_rdv,
    input logic e_start, input logic e_busy, input logic chk_txn, input logic e_write,
    input logic [7:0] e_addr, input logic [7:0] e_wdata, input logic [7:0] e_rdata);
    vec_t v;
    v.rst = rst;         v.req = req;         v.addr = addr;       v.done = done;
    v.rdata = rdata;     v.e_gnt = e_gnt;     v.e_rdv = e_rdv;     v.e_start = e_start;
    v.e_busy = e_busy;   v.chk_txn = chk_txn; v.e_write = e_write; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       ok;
    logic       seen;
    logic [2:0] e_one;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_fp.req = '0;  bus_fp.req_write = WMODE; bus_fp.req_addr = ADDR_A; bus_fp.req_wdata = WDATA;
    bus_fp.txn_done = 1'b0; bus_fp.txn_rdata = '0;
    bus_rr.req = '0;  bus_rr.req_write = '0;    bus_rr.req_addr = ADDR_A; bus_rr.req_wdata = WDATA;
    bus_rr.txn_done = 1'b0; bus_rr.txn_rdata = '0;

    //              rst req     addr    dn rdata  | gnt     rdv     st bsy ck wr addr   wdata  rd_data
    vecs.push_back(mk(1, 3'b111, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1, 3'b111, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1, 3'b111, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(0, 3'b111, ADDR_A, 0, 8'h00, 3'b001, 3'b000, 1, 1, 1, 0, 8'h20, 8'h00, 8'h00));
    vecs.push_back(mk(0, 3'b110, ADDR_A, 0, 8'h00, 3'b001, 3'b000, 0, 1, 1, 0, 8'h20, 8'h00, 8'h00));
    vecs.push_back(mk(0, 3'b110, ADDR_A, 1, 8'hA5, 3'b000, 3'b001, 0, 1, 0, 0, 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(0, 3'b110, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 1, 0, 0, 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(0, 3'b110, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(0, 3'b110, ADDR_A, 0, 8'h00, 3'b010, 3'b000, 1, 1, 1, 0, 8'h21, 8'h00, 8'hA5));
    vecs.push_back(mk(0, 3'b110, ADDR_B, 0, 8'h00, 3'b010, 3'b000, 0, 1, 1, 0, 8'h21, 8'h00, 8'hA5));
    vecs.push_back(mk(0, 3'b110, ADDR_A, 1, 8'h45, 3'b000, 3'b010, 0, 1, 0, 0, 8'h00, 8'h00, 8'h45));
    vecs.push_back(mk(0, 3'b100, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 1, 0, 0, 8'h00, 8'h00, 8'h45));
    vecs.push_back(mk(0, 3'b100, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 8'h00, 8'h00, 8'h45));
    vecs.push_back(mk(0, 3'b100, ADDR_A, 0, 8'h00, 3'b100, 3'b000, 1, 1, 1, 1, 8'h22, 8'h59, 8'h45));
    vecs.push_back(mk(0, 3'b000, ADDR_A, 1, 8'hEE, 3'b000, 3'b000, 0, 1, 0, 0, 8'h00, 8'h00, 8'h45));
    vecs.push_back(mk(0, 3'b000, ADDR_A, 1, 8'h11, 3'b000, 3'b000, 0, 1, 0, 0, 8'h00, 8'h00, 8'h45));
    vecs.push_back(mk(0, 3'b000, ADDR_A, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 0, 8'h00, 8'h00, 8'h45));
    vecs.push_back(mk(0, 3'b000, ADDR_A, 1, 8'h22, 3'b000, 3'b000, 0, 0, 0, 0, 8'h00, 8'h00, 8'h45));

    foreach (vecs[i]) begin
      reset            = vecs[i].rst;
      bus_fp.req       = vecs[i].req;
      bus_fp.req_addr  = vecs[i].addr;
      bus_fp.txn_done  = vecs[i].done;
      bus_fp.txn_rdata = vecs[i].rdata;
      tick();
      check($sformatf("v%0d gnt", i),       bus_fp.gnt,       vecs[i].e_gnt);
      check($sformatf("v%0d rd_valid", i),  bus_fp.rd_valid,  vecs[i].e_rdv);
      check($sformatf("v%0d err", i),       bus_fp.err,       3'b000);
      check($sformatf("v%0d txn_start", i), bus_fp.txn_start, vecs[i].e_start);
      check($sformatf("v%0d busy", i),      bus_fp.busy,      vecs[i].e_busy);
      check($sformatf("v%0d rd_data", i),   bus_fp.rd_data,   vecs[i].e_rdata);
      if (vecs[i].chk_txn) begin
        check($sformatf("v%0d txn_write", i), bus_fp.txn_write, vecs[i].e_write);
        check($sformatf("v%0d txn_addr", i),  bus_fp.txn_addr,  vecs[i].e_addr);
        check($sformatf("v%0d txn_wdata", i), bus_fp.txn_wdata, vecs[i].e_wdata);
      end
    end
    bus_fp.txn_done = 1'b0;
    bus_fp.req_addr = ADDR_A;

    // Timeout: client 0 drops req after grant, engine never answers, 20 WAIT cycles then err.
    bus_fp.req = 3'b001;
    tick();
    check("to_grant", bus_fp.gnt, 3'b001);
    bus_fp.req = 3'b000;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus_fp.gnt !== 3'b001 || bus_fp.err !== 3'b000) ok = 1'b0;
    end
    check("to_hold", ok, 1'b1);
    tick();
    check("to_err", bus_fp.err, 3'b001);
    check("to_gnt", bus_fp.gnt, 3'b000);
    check("to_busy", bus_fp.busy, 1'b1);
    check("to_rdv", bus_fp.rd_valid, 3'b000);
    tick();
    check("to_err_pulse", bus_fp.err, 3'b000);
    check("to_guard", bus_fp.busy, 1'b1);
    tick();
    check("to_idle", bus_fp.busy, 1'b0);

    // Done on the same edge the timeout would fire: completion wins.
    bus_fp.req = 3'b001;
    tick();
    check("tc_grant", bus_fp.gnt, 3'b001);
    bus_fp.req = 3'b000;
    for (int c = 0; c < 20; c++) tick();
    bus_fp.txn_done  = 1'b1;
    bus_fp.txn_rdata = 8'h3C;
    tick();
    bus_fp.txn_done = 1'b0;
    check("tc_err", bus_fp.err, 3'b000);
    check("tc_rdv", bus_fp.rd_valid, 3'b001);
    check("tc_rd_data", bus_fp.rd_data, 8'h3C);
    check("tc_gnt", bus_fp.gnt, 3'b000);
    tick();
    tick();
    check("tc_idle", bus_fp.busy, 1'b0);

    // Reset during WAIT drops ownership; a late done afterwards is ignored.
    bus_fp.req = 3'b010;
    tick();
    bus_fp.req = 3'b000;
    tick();
    check("rw_wait_gnt", bus_fp.gnt, 3'b010);
    check("rw_wait_busy", bus_fp.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_gnt", bus_fp.gnt, 3'b000);
    check("rw_busy", bus_fp.busy, 1'b0);
    check("rw_rd_data", bus_fp.rd_data, 8'h00);
    bus_fp.txn_done  = 1'b1;
    bus_fp.txn_rdata = 8'h77;
    tick();
    bus_fp.txn_done = 1'b0;
    check("rw_late_rdv", bus_fp.rd_valid, 3'b000);
    check("rw_late_busy", bus_fp.busy, 1'b0);
    check("rw_late_rd_data", bus_fp.rd_data, 8'h00);

    // Round robin: all three request continuously, grants rotate 0,1,2,0,1,2.
    bus_rr.req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      e_one = 3'b001 << (t % 3);
      seen  = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        tick();
        if (bus_rr.txn_start === 1'b1) seen = 1'b1;
      end
      check($sformatf("rr%0d start", t), seen, 1'b1);
      check($sformatf("rr%0d gnt", t), bus_rr.gnt, e_one);
      check($sformatf("rr%0d addr", t), bus_rr.txn_addr, 8'h20 + 8'(t % 3));
      bus_rr.txn_done  = 1'b1;
      bus_rr.txn_rdata = 8'h60 + 8'(t);
      tick();
      bus_rr.txn_done = 1'b0;
      check($sformatf("rr%0d rdv", t), bus_rr.rd_valid, e_one);
      check($sformatf("rr%0d rd_data", t), bus_rr.rd_data, 8'h60 + 8'(t));
    end
    bus_rr.req = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
